fdivsqrt_wb_buffer: RTL and testbench
=====================================

# fdivsqrt_wb_buffer

Result staging buffer between the FP divide/sqrt unit and the shared FP writeback/commit path. Captures each single-cycle completion pulse (physical dest, ROB index, 64-bit data, fflags) into a small FIFO and presents it on a valid/ready writeback port, so the non-stallable divide/sqrt unit never loses a result when the writeback arbiter is busy. Tracks the format of the in-flight operation for NaN-boxing of single-precision results, and throttles issue via a credit signal.

## Interface
- PHY_REG_ADDR_WIDTH, 6: physical register address width.
- ROB_INDEX_WIDTH, 6: ROB index width.
- XLEN, 64: data width.
- DEPTH, 2: FIFO entries, power of two, ≥2.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- trap  in  1  pipeline flush; same effect as rst on buffer contents, one cycle.
- issue_fire_i  in  1  request accepted by the divide/sqrt unit this cycle (valid & ready at its input).
- issue_fmt_i  in  2  format of accepted request (00 = single, 01 = double).
- issue_credit_o  out  1  issue may send a new request; AND into the unit's request-ready.
- fu_resp_valid_i  in  1  completion pulse from the unit.
- fu_prd_addr_i  in  PHY_REG_ADDR_WIDTH  destination physical register.
- fu_rob_index_i  in  ROB_INDEX_WIDTH  ROB index.
- fu_data_i  in  XLEN  result; single results zero-extended in [63:32].
- fu_fflags_i  in  5  exception flags.
- wb_valid_o  out  1  head entry valid.
- wb_ready_i  in  1  writeback arbiter accepts.
- wb_prd_addr_o  out  PHY_REG_ADDR_WIDTH.
- wb_rob_index_o  out  ROB_INDEX_WIDTH.
- wb_data_o  out  XLEN.
- wb_fflags_vld_o  out  1  equals wb_valid_o.
- wb_fflags_o  out  5.

## Operation
- Format tracker: fmt_q loads issue_fmt_i on issue_fire_i; inflight_q sets on issue_fire_i, clears on fu_resp_valid_i. A fu_resp_valid_i arriving with inflight_q = 0 is a protocol error (assertion); entry still written.
- Enqueue: on fu_resp_valid_i and not trap, write {prd, rob, data', fflags} at wr_ptr; data' per Configuration using fmt_q.
- Dequeue: on wb_valid_o & wb_ready_i, advance rd_ptr.
- Pointers: log2(DEPTH)+1 bits, wrap modulo 2·DEPTH; empty = pointers equal; full = MSBs differ, rest equal. count = wr_ptr − rd_ptr.
- Simultaneous enqueue and dequeue: both pointers advance, count unchanged; legal when full (dequeue frees slot same cycle) and when empty (write lands, output valid next cycle, no bypass).
- Credit: issue_credit_o = !inflight_q & (count + inflight_q < DEPTH) — guarantees a free slot for every outstanding result. Since at most one op is in flight, enqueue while full and no dequeue cannot occur; assert it never does.
- trap/rst: pointers, inflight_q cleared; fmt_q to 00; entries not cleared (don't-care). A fu_resp_valid_i or issue_fire_i in the trap cycle is dropped.
- Outputs driven from head entry; wb_valid_o = !empty.

## Timing
- Reset values: wb_valid_o 0, wb_fflags_vld_o 0, issue_credit_o 1; data/addr/flag outputs X-free (head register content after reset is 0).
- Latency: fu_resp_valid_i in cycle N → wb_valid_o high in N+1.
- Output held stable while wb_valid_o & !wb_ready_i.
- issue_credit_o drops the cycle after issue_fire_i; rises the cycle after the result's dequeue frees capacity (registered state only, no combinational path from wb_ready_i).
- Throughput: one writeback per cycle.

## Configuration
- FDIVSQRT_WB_NANBOX_EN defined: when fmt_q = 00, data' = {32'hFFFF_FFFF, fu_data_i[31:0]}; double passes unchanged.
- Undefined: data' = fu_data_i for all formats (consumer NaN-boxes).

## Structure
- Shared package: entry struct/width constant (prd + rob + XLEN + 5), FMT_S = 2'b00, FMT_D = 2'b01; PHY_REG_ADDR_WIDTH/ROB_INDEX_WIDTH/XLEN from existing params header.
- One sub-module: fdivsqrt_wb_fifo (generic DEPTH × width sync FIFO with full/empty/count); top holds tracker, credit and NaN-box logic.

## Test plan
- Single pass: issue fmt 01, resp prd 5, rob 3, data 64'h4000_0000_0000_0000, fflags 0, wb_ready 1 → wb_valid next cycle with same fields for one cycle; credit back.
- NaN-box: fmt 00, data 64'h0000_0000_3F80_0000 → with macro 64'hFFFF_FFFF_3F80_0000, without unchanged.
- Backpressure: wb_ready 0 for 10 cycles across two ops → second issue blocked until slot free; both results emerge in order, held stable.
- Full + simultaneous: DEPTH 2 full, wb_ready 1 same cycle as new resp → count stays 2, no loss, order preserved.
- Trap mid-operation: issue, trap before resp → wb_valid 0, credit 1 next cycle; trap coincident with resp → result dropped.
- Reset: rst with 2 entries queued → wb_valid 0, credit 1 next cycle.

Source files
------------

// File: rtl/fdivsqrt_wb_buffer_pkg.sv
// Shared types and widths for the divide/sqrt writeback staging buffer.
package fdivsqrt_wb_buffer_pkg;

  localparam int unsigned PHY_REG_ADDR_WIDTH = 6;
  localparam int unsigned ROB_INDEX_WIDTH    = 6;
  localparam int unsigned XLEN               = 64;
  localparam int unsigned FFLAGS_WIDTH       = 5;
  localparam int unsigned FMT_WIDTH          = 2;

  localparam logic [FMT_WIDTH-1:0] FMT_S = 2'b00;
  localparam logic [FMT_WIDTH-1:0] FMT_D = 2'b01;

  typedef struct packed {
    logic [PHY_REG_ADDR_WIDTH-1:0] prd;
    logic [ROB_INDEX_WIDTH-1:0]    rob;
    logic [XLEN-1:0]               data;
    logic [FFLAGS_WIDTH-1:0]       fflags;
  } wb_entry_t;

  localparam int unsigned WB_ENTRY_WIDTH =
    PHY_REG_ADDR_WIDTH + ROB_INDEX_WIDTH + XLEN + FFLAGS_WIDTH;

endpackage

// File: rtl/fdivsqrt_wb_buffer_if.sv
// Completion-in and writeback-out bundle of the divide/sqrt staging buffer.
// master = the buffer, slave = the unit/arbiter side.
interface fdivsqrt_wb_buffer_if;
  import fdivsqrt_wb_buffer_pkg::*;

  logic                          fu_resp_valid_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] fu_prd_addr_i;
  logic [ROB_INDEX_WIDTH-1:0]    fu_rob_index_i;
  logic [XLEN-1:0]               fu_data_i;
  logic [FFLAGS_WIDTH-1:0]       fu_fflags_i;

  logic                          wb_valid_o;
  logic                          wb_ready_i;
  logic [PHY_REG_ADDR_WIDTH-1:0] wb_prd_addr_o;
  logic [ROB_INDEX_WIDTH-1:0]    wb_rob_index_o;
  logic [XLEN-1:0]               wb_data_o;
  logic                          wb_fflags_vld_o;
  logic [FFLAGS_WIDTH-1:0]       wb_fflags_o;

  modport master (
    input  fu_resp_valid_i, fu_prd_addr_i, fu_rob_index_i, fu_data_i, fu_fflags_i,
    input  wb_ready_i,
    output wb_valid_o, wb_prd_addr_o, wb_rob_index_o, wb_data_o,
    output wb_fflags_vld_o, wb_fflags_o
  );

  modport slave (
    output fu_resp_valid_i, fu_prd_addr_i, fu_rob_index_i, fu_data_i, fu_fflags_i,
    output wb_ready_i,
    input  wb_valid_o, wb_prd_addr_o, wb_rob_index_o, wb_data_o,
    input  wb_fflags_vld_o, wb_fflags_o
  );

endinterface

// File: rtl/fdivsqrt_wb_fifo.sv
// Generic synchronous FIFO, DEPTH (power of two) x WIDTH, with wrap-bit pointers.
// flush clears pointers only; rst also zeroes storage so the head is X-free.
module fdivsqrt_wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned PW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c,
  output logic [PW-1:0]    count_c
);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_wr, do_rd;

  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_c   = wr_ptr_q - rd_ptr_q;
  assign rd_data_c = mem_q[rd_ptr_q[AW-1:0]];

  // A write into a full FIFO is only taken when the head leaves the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    do_wr    = wr_en && (!full_c || rd_en);
    do_rd    = rd_en && !empty_c;
    if (do_wr) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      mem_q    <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/fdivsqrt_wb_buffer.sv
// Stages divide/sqrt completions into a FIFO for the shared writeback port and
// meters issue credit. Define FDIVSQRT_WB_NANBOX_EN to NaN-box single results here.
module fdivsqrt_wb_buffer
  import fdivsqrt_wb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trap,
  input  logic                 issue_fire_i,
  input  logic [FMT_WIDTH-1:0] issue_fmt_i,
  output logic                 issue_credit_o,
  fdivsqrt_wb_buffer_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [FMT_WIDTH-1:0]      fmt_q, fmt_d;
  logic                      inflight_q, inflight_d;
  wb_entry_t                 enq_entry, head_entry;
  logic [WB_ENTRY_WIDTH-1:0] head_bits;
  logic                      fifo_wr, fifo_rd, fifo_full, fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [OCC_W-1:0]          occupancy;

  // Format / in-flight tracker; a flush wins over any same-cycle issue.
  always_comb begin
    fmt_d      = fmt_q;
    inflight_d = inflight_q;
    if (bus.fu_resp_valid_i) begin
      inflight_d = 1'b0;
    end
    if (issue_fire_i) begin
      fmt_d      = issue_fmt_i;
      inflight_d = 1'b1;
    end
    if (trap) begin
      fmt_d      = FMT_S;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fmt_q      <= FMT_S;
      inflight_q <= 1'b0;
    end else begin
      fmt_q      <= fmt_d;
      inflight_q <= inflight_d;
    end
  end

  always_comb begin
    enq_entry.prd    = bus.fu_prd_addr_i;
    enq_entry.rob    = bus.fu_rob_index_i;
    enq_entry.fflags = bus.fu_fflags_i;
`ifdef FDIVSQRT_WB_NANBOX_EN
    if (fmt_q == FMT_S) begin
      enq_entry.data = {{(XLEN-32){1'b1}}, bus.fu_data_i[31:0]};
    end else begin
      enq_entry.data = bus.fu_data_i;
    end
`else
    enq_entry.data = bus.fu_data_i;
`endif
  end

  assign fifo_wr = bus.fu_resp_valid_i && !trap;
  assign fifo_rd = !fifo_empty && bus.wb_ready_i && !trap;

  fdivsqrt_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WB_ENTRY_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (trap),
    .wr_en     (fifo_wr),
    .wr_data   (enq_entry),
    .rd_en     (fifo_rd),
    .rd_data_c (head_bits),
    .full_c    (fifo_full),
    .empty_c   (fifo_empty),
    .count_c   (fifo_count)
  );

  assign head_entry = wb_entry_t'(head_bits);

  assign bus.wb_valid_o      = !fifo_empty;
  assign bus.wb_fflags_vld_o = !fifo_empty;
  assign bus.wb_prd_addr_o   = head_entry.prd;
  assign bus.wb_rob_index_o  = head_entry.rob;
  assign bus.wb_data_o       = head_entry.data;
  assign bus.wb_fflags_o     = head_entry.fflags;

  // Reserve a slot for the outstanding result; depends on registered state only.
  assign occupancy      = OCC_W'(fifo_count) + OCC_W'(inflight_q);
  assign issue_credit_o = !inflight_q && (occupancy < OCC_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(bus.fu_resp_valid_i && !inflight_q));
      assert (!(fifo_wr && fifo_full && !fifo_rd));
    end
  end

endmodule

// File: tb/tb_fdivsqrt_wb_buffer.sv
// Directed self-checking bench for fdivsqrt_wb_buffer (DEPTH 2).
module tb_fdivsqrt_wb_buffer;
  import fdivsqrt_wb_buffer_pkg::*;

  logic clk = 1'b0;
  logic rst, trap, issue_fire_i, issue_credit_o;
  logic [1:0] issue_fmt_i;
  int checks = 0;
  int errors = 0;

  fdivsqrt_wb_buffer_if bus();

  fdivsqrt_wb_buffer #(.DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .trap           (trap),
    .issue_fire_i   (issue_fire_i),
    .issue_fmt_i    (issue_fmt_i),
    .issue_credit_o (issue_credit_o),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_issue(input logic [1:0] fmt);
    issue_fire_i = 1'b1;
    issue_fmt_i  = fmt;
    tick();
    issue_fire_i = 1'b0;
  endtask

  task automatic do_resp(input logic [5:0] prd, input logic [5:0] rob,
                         input logic [63:0] data, input logic [4:0] ff);
    bus.fu_resp_valid_i = 1'b1;
    bus.fu_prd_addr_i   = prd;
    bus.fu_rob_index_i  = rob;
    bus.fu_data_i       = data;
    bus.fu_fflags_i     = ff;
    tick();
    bus.fu_resp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.wb_valid_o); end
    checks++; if (bus.wb_fflags_vld_o !== 1'b0) begin errors++; $display("FAIL reset_fvld: got %b expected 0", bus.wb_fflags_vld_o); end
    checks++; if (issue_credit_o !== 1'b1) begin errors++; $display("FAIL reset_credit: got %b expected 1", issue_credit_o); end
    checks++; if (bus.wb_data_o !== 64'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.wb_data_o); end
    checks++; if ({bus.wb_prd_addr_o, bus.wb_rob_index_o, bus.wb_fflags_o} !== 17'h0) begin errors++;
      $display("FAIL reset_fields: got %h expected 0", {bus.wb_prd_addr_o, bus.wb_rob_index_o, bus.wb_fflags_o}); end
  endtask

  task automatic test_single_pass();
    bus.wb_ready_i = 1'b1;
    do_issue(FMT_D);
    checks++; if (issue_credit_o !== 1'b0) begin errors++; $display("FAIL sp_credit_drop: got %b expected 0", issue_credit_o); end
    do_resp(6'd5, 6'd3, 64'h4000_0000_0000_0000, 5'd0);
    checks++; if (bus.wb_valid_o !== 1'b1) begin errors++; $display("FAIL sp_valid: got %b expected 1", bus.wb_valid_o); end
    checks++; if (bus.wb_fflags_vld_o !== 1'b1) begin errors++; $display("FAIL sp_fvld: got %b expected 1", bus.wb_fflags_vld_o); end
    checks++; if (bus.wb_data_o !== 64'h4000_0000_0000_0000) begin errors++; $display("FAIL sp_data: got %h expected 4000000000000000", bus.wb_data_o); end
    checks++; if (bus.wb_prd_addr_o !== 6'd5 || bus.wb_rob_index_o !== 6'd3 || bus.wb_fflags_o !== 5'd0) begin errors++;
      $display("FAIL sp_fields: got prd %0d rob %0d ff %0h expected 5 3 0", bus.wb_prd_addr_o, bus.wb_rob_index_o, bus.wb_fflags_o); end
    checks++; if (issue_credit_o !== 1'b1) begin errors++; $display("FAIL sp_credit_back: got %b expected 1", issue_credit_o); end
    tick();
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL sp_one_cycle: got %b expected 0", bus.wb_valid_o); end
  endtask

  task automatic test_nanbox();
    logic [63:0] exp_data;
`ifdef FDIVSQRT_WB_NANBOX_EN
    exp_data = 64'hFFFF_FFFF_3F80_0000;
`else
    exp_data = 64'h0000_0000_3F80_0000;
`endif
    bus.wb_ready_i = 1'b0;
    do_issue(FMT_S);
    do_resp(6'd7, 6'd9, 64'h0000_0000_3F80_0000, 5'd1);
    checks++; if (bus.wb_data_o !== exp_data) begin errors++; $display("FAIL nanbox_data: got %h expected %h", bus.wb_data_o, exp_data); end
    checks++; if (bus.wb_fflags_o !== 5'd1 || bus.wb_prd_addr_o !== 6'd7) begin errors++;
      $display("FAIL nanbox_fields: got ff %0h prd %0d expected 1 7", bus.wb_fflags_o, bus.wb_prd_addr_o); end
    bus.wb_ready_i = 1'b1;
    tick();
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL nanbox_drain: got %b expected 0", bus.wb_valid_o); end
  endtask

  task automatic test_backpressure();
    bus.wb_ready_i = 1'b0;
    do_issue(FMT_D);
    do_resp(6'd1, 6'd11, 64'hAAAA_0000_0000_1111, 5'd2);
    checks++; if (issue_credit_o !== 1'b1) begin errors++; $display("FAIL bp_credit_one: got %b expected 1", issue_credit_o); end
    do_issue(FMT_D);
    checks++; if (issue_credit_o !== 1'b0) begin errors++; $display("FAIL bp_credit_issue2: got %b expected 0", issue_credit_o); end
    do_resp(6'd2, 6'd12, 64'hBBBB_0000_0000_2222, 5'd4);
    for (int i = 0; i < 8; i++) begin
      checks++; if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== 64'hAAAA_0000_0000_1111 || bus.wb_rob_index_o !== 6'd11) begin errors++;
        $display("FAIL bp_hold[%0d]: got v %b data %h rob %0d expected 1 aaaa000000001111 11", i, bus.wb_valid_o, bus.wb_data_o, bus.wb_rob_index_o); end
      checks++; if (issue_credit_o !== 1'b0) begin errors++; $display("FAIL bp_blocked[%0d]: got %b expected 0", i, issue_credit_o); end
      tick();
    end
    bus.wb_ready_i = 1'b1;
    tick();
    checks++; if (bus.wb_data_o !== 64'hBBBB_0000_0000_2222 || bus.wb_fflags_o !== 5'd4 || bus.wb_prd_addr_o !== 6'd2) begin errors++;
      $display("FAIL bp_second: got data %h ff %0h prd %0d expected bbbb000000002222 4 2", bus.wb_data_o, bus.wb_fflags_o, bus.wb_prd_addr_o); end
    checks++; if (issue_credit_o !== 1'b1) begin errors++; $display("FAIL bp_credit_free: got %b expected 1", issue_credit_o); end
    tick();
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", bus.wb_valid_o); end
  endtask

  task automatic test_full_simultaneous();
    bus.wb_ready_i = 1'b0;
    do_issue(FMT_D);
    do_resp(6'd20, 6'd1, 64'h0000_0000_0000_00A1, 5'd0);
    do_issue(FMT_D);
    do_resp(6'd21, 6'd2, 64'h0000_0000_0000_00B2, 5'd0);
    checks++; if (issue_credit_o !== 1'b0) begin errors++; $display("FAIL fs_full_credit: got %b expected 0", issue_credit_o); end
    // Forced third issue so a completion can meet a full buffer.
    do_issue(FMT_D);
    bus.wb_ready_i = 1'b1;
    do_resp(6'd22, 6'd3, 64'h0000_0000_0000_00C3, 5'd0);
    checks++; if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== 64'hB2) begin errors++;
      $display("FAIL fs_head_b: got v %b data %h expected 1 b2", bus.wb_valid_o, bus.wb_data_o); end
    checks++; if (issue_credit_o !== 1'b0) begin errors++; $display("FAIL fs_count2: got %b expected 0", issue_credit_o); end
    tick();
    checks++; if (bus.wb_valid_o !== 1'b1 || bus.wb_data_o !== 64'hC3 || bus.wb_prd_addr_o !== 6'd22) begin errors++;
      $display("FAIL fs_head_c: got v %b data %h prd %0d expected 1 c3 22", bus.wb_valid_o, bus.wb_data_o, bus.wb_prd_addr_o); end
    tick();
    checks++; if (bus.wb_valid_o !== 1'b0 || issue_credit_o !== 1'b1) begin errors++;
      $display("FAIL fs_drained: got v %b credit %b expected 0 1", bus.wb_valid_o, issue_credit_o); end
  endtask

  task automatic test_trap();
    bus.wb_ready_i = 1'b1;
    do_issue(FMT_D);
    trap = 1'b1;
    tick();
    trap = 1'b0;
    checks++; if (bus.wb_valid_o !== 1'b0 || issue_credit_o !== 1'b1) begin errors++;
      $display("FAIL trap_mid: got v %b credit %b expected 0 1", bus.wb_valid_o, issue_credit_o); end
    do_issue(FMT_D);
    trap = 1'b1;
    do_resp(6'd30, 6'd30, 64'hDEAD_BEEF_0000_0001, 5'd3);
    trap = 1'b0;
    checks++; if (bus.wb_valid_o !== 1'b0 || issue_credit_o !== 1'b1) begin errors++;
      $display("FAIL trap_coincident: got v %b credit %b expected 0 1", bus.wb_valid_o, issue_credit_o); end
    tick();
    checks++; if (bus.wb_valid_o !== 1'b0) begin errors++; $display("FAIL trap_dropped: got %b expected 0", bus.wb_valid_o); end
  endtask

  task automatic test_reset_queued();
    bus.wb_ready_i = 1'b0;
    do_issue(FMT_D);
    do_resp(6'd3, 6'd4, 64'h1, 5'd0);
    do_issue(FMT_D);
    do_resp(6'd5, 6'd6, 64'h2, 5'd0);
    checks++; if (bus.wb_valid_o !== 1'b1) begin errors++; $display("FAIL rq_queued: got %b expected 1", bus.wb_valid_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.wb_valid_o !== 1'b0 || issue_credit_o !== 1'b1) begin errors++;
      $display("FAIL rq_after_rst: got v %b credit %b expected 0 1", bus.wb_valid_o, issue_credit_o); end
  endtask

  initial begin
    rst = 1'b1;
    trap = 1'b0;
    issue_fire_i = 1'b0;
    issue_fmt_i = 2'b00;
    bus.fu_resp_valid_i = 1'b0;
    bus.fu_prd_addr_i = '0;
    bus.fu_rob_index_i = '0;
    bus.fu_data_i = '0;
    bus.fu_fflags_i = '0;
    bus.wb_ready_i = 1'b0;
    test_reset();
    test_single_pass();
    test_nanbox();
    test_backpressure();
    test_full_simultaneous();
    test_trap();
    test_reset_queued();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
